// File: rtl/tick_rx_if.sv
// Slow-tick receive bundle: the incoming divided clock and everything the monitor reports about it.
interface tick_rx_if #(
  parameter int CNT_W  = 20,
  parameter int MISS_W = 8
);
  logic              tick_in;
  logic              tick_pulse;
  logic              locked;
  logic [CNT_W-1:0]  period;
  logic              err_short;
  logic              err_long;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output tick_in,
    input  tick_pulse, locked, period, err_short, err_long, miss_count
  );

  modport slave (
    input  tick_in,
    output tick_pulse, locked, period, err_short, err_long, miss_count
  );
endinterface

// File: rtl/tick_rx_monitor.sv
// Receives the divided slow clock, emits one tick per rising edge, measures periods and tracks lock.
// Build option TICK_GATE_EN: only ticks from edges that leave the monitor LOCKED are forwarded.
module tick_rx_monitor #(
  parameter int NOMINAL_CYCLES = 833336,
  parameter int TOL            = 8333,
  parameter int LOCK_COUNT     = 4,
  parameter int CNT_W          = 20,
  parameter int MISS_W         = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      internal_reset,
  tick_rx_if.slave  bus
);

  localparam int                GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(NOMINAL_CYCLES - TOL);
  localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(NOMINAL_CYCLES + TOL);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_TOP = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              s1_r, s2_r, s3_r;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  period_r, period_s;
  logic [CNT_W-1:0]  measured_s;
  logic [GOOD_W-1:0] good_r, good_s;
  logic [MISS_W-1:0] miss_r, miss_s;
  logic              edge_s, timeout_s, short_s;
  logic              tick_r, tick_s;
  logic              err_short_r, err_short_s;
  logic              err_long_r, err_long_s;
  logic              locked_r, locked_s;

  assign edge_s     = s2_r & ~s3_r;
  assign measured_s = cnt_r + CNT_W'(1);
  assign short_s    = (measured_s < MIN_P);
  // Timeout can coincide with an edge; the edge then restarts acquisition instead of being measured.
  assign timeout_s  = (state_r != ST_IDLE) && (cnt_r == MAX_P);

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else if (internal_reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= bus.tick_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Lock FSM state and good-period run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      good_r  <= {GOOD_W{1'b0}};
    end else if (internal_reset) begin
      state_r <= ST_IDLE;
      good_r  <= {GOOD_W{1'b0}};
    end else begin
      state_r <= state_s;
      good_r  <= good_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    good_s  = good_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          state_s = ST_ACQUIRE;
          good_s  = {GOOD_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACQUIRE: begin
        if (timeout_s) begin
          state_s = edge_s ? ST_ACQUIRE : ST_IDLE;
          good_s  = {GOOD_W{1'b0}};
        end else if (edge_s && short_s) begin
          good_s = {GOOD_W{1'b0}};
        end else if (edge_s) begin
          if (good_r == GOOD_TOP) begin
            state_s = ST_LOCKED;
            good_s  = {GOOD_W{1'b0}};
          end else begin
            good_s = good_r + GOOD_W'(1);
          end
        end else begin
          state_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (timeout_s) begin
          state_s = edge_s ? ST_ACQUIRE : ST_IDLE;
          good_s  = {GOOD_W{1'b0}};
        end else if (edge_s && short_s) begin
          state_s = ST_ACQUIRE;
          good_s  = {GOOD_W{1'b0}};
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_IDLE;
        good_s  = {GOOD_W{1'b0}};
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_s       = cnt_r;
    period_s    = period_r;
    miss_s      = miss_r;
    err_long_s  = timeout_s;
    err_short_s = edge_s && short_s && !timeout_s && (state_r != ST_IDLE);
    locked_s    = (state_s == ST_LOCKED);
    if (edge_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
    if (edge_s && !timeout_s && (state_r != ST_IDLE)) begin
      period_s = measured_s;
    end else begin
      period_s = period_r;
    end
    if (timeout_s && (state_r == ST_LOCKED) && (miss_r != MISS_MAX)) begin
      miss_s = miss_r + MISS_W'(1);
    end else begin
      miss_s = miss_r;
    end
`ifdef TICK_GATE_EN
    tick_s = edge_s && (state_s == ST_LOCKED);
`else
    tick_s = edge_s;
`endif
  end

  // Registered counter and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      period_r    <= {CNT_W{1'b0}};
      miss_r      <= {MISS_W{1'b0}};
      tick_r      <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      locked_r    <= 1'b0;
    end else if (internal_reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      period_r    <= {CNT_W{1'b0}};
      miss_r      <= {MISS_W{1'b0}};
      tick_r      <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      cnt_r       <= cnt_s;
      period_r    <= period_s;
      miss_r      <= miss_s;
      tick_r      <= tick_s;
      err_short_r <= err_short_s;
      err_long_r  <= err_long_s;
      locked_r    <= locked_s;
    end
  end

  assign bus.tick_pulse = tick_r;
  assign bus.locked     = locked_r;
  assign bus.period     = period_r;
  assign bus.err_short  = err_short_r;
  assign bus.err_long   = err_long_r;
  assign bus.miss_count = miss_r;

endmodule

// File: tb/tb_tick_rx_monitor.sv
// Scoreboard bench for tick_rx_monitor with a small period (100 cycles, +/-2, lock after 4 good periods).
module tb_tick_rx_monitor;

  localparam int NOM   = 100;
  localparam int TOL   = 2;
  localparam int LOCKN = 4;
  localparam int MIN_P = NOM - TOL;
  localparam int MAX_P = NOM + TOL;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic        tick;
    logic        es;
    logic        el;
    logic        lk;
    logic [7:0]  per;
    logic [7:0]  miss;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic internal_reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  sb_q[$];

  int        m_state = M_IDLE;
  int        m_good = 0;
  int        m_last = 0;
  logic [7:0] m_period = 8'd0;
  logic [7:0] m_miss = 8'd0;

  tick_rx_if #(.CNT_W(8), .MISS_W(8)) bus ();

  tick_rx_monitor #(
    .NOMINAL_CYCLES(NOM), .TOL(TOL), .LOCK_COUNT(LOCKN), .CNT_W(8), .MISS_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .internal_reset(internal_reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Pop and compare one expected event whenever the DUT reports something.
  always @(negedge clk) begin
    ev_t obs;
    ev_t exp;
    obs = '{cyc: cyc, tick: bus.tick_pulse, es: bus.err_short, el: bus.err_long,
            lk: bus.locked, per: bus.period, miss: bus.miss_count};
    if (bus.tick_pulse || bus.err_short || bus.err_long) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d tick=%b es=%b el=%b", cyc, obs.tick, obs.es, obs.el);
      end else begin
        exp = sb_q.pop_front();
        if (obs !== exp) begin
          bad++;
          $display("FAIL event got cyc=%0d tick=%b es=%b el=%b lk=%b per=%0d miss=%0d want cyc=%0d tick=%b es=%b el=%b lk=%b per=%0d miss=%0d",
                   obs.cyc, obs.tick, obs.es, obs.el, obs.lk, obs.per, obs.miss,
                   exp.cyc, exp.tick, exp.es, exp.el, exp.lk, exp.per, exp.miss);
        end
      end
    end else if (sb_q.size() != 0 && int'(sb_q[0].cyc) < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_event want cyc=%0d now=%0d", sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
  end

  // Event-level reference: a rise driven at cycle r is seen as an edge at r+3.
  task automatic model_rise(input int r, input int p);
    ev_t ev;
    int  e;
    int  iv;
    e  = r + 3;
    iv = e - m_last;
    ev.cyc = e;
    ev.es  = 1'b0;
    ev.el  = 1'b0;
    if (m_state == M_IDLE) begin
      m_state = M_ACQ;
      m_good  = 0;
    end else if (iv == MAX_P + 1) begin
      ev.el = 1'b1;
      if (m_state == M_LOCK && m_miss != 8'hFF) m_miss = m_miss + 8'd1;
      m_state = M_ACQ;
      m_good  = 0;
    end else if (iv < MIN_P) begin
      ev.es    = 1'b1;
      m_period = iv[7:0];
      m_state  = M_ACQ;
      m_good   = 0;
    end else begin
      m_period = iv[7:0];
      if (m_state == M_ACQ) begin
        if (m_good == LOCKN - 1) begin
          m_state = M_LOCK;
          m_good  = 0;
        end else begin
          m_good = m_good + 1;
        end
      end
    end
`ifdef TICK_GATE_EN
    ev.tick = (m_state == M_LOCK);
`else
    ev.tick = 1'b1;
`endif
    ev.lk   = (m_state == M_LOCK);
    ev.per  = m_period;
    ev.miss = m_miss;
    if (ev.tick || ev.es || ev.el) sb_q.push_back(ev);
    m_last = e;
    // A gap longer than MAX_P+1 times out before the next edge arrives.
    if (m_state != M_IDLE && p > MAX_P + 1) begin
      ev.cyc  = e + MAX_P + 1;
      ev.tick = 1'b0;
      ev.es   = 1'b0;
      ev.el   = 1'b1;
      if (m_state == M_LOCK && m_miss != 8'hFF) m_miss = m_miss + 8'd1;
      m_state = M_IDLE;
      ev.lk   = 1'b0;
      ev.miss = m_miss;
      sb_q.push_back(ev);
    end
  endtask

  task automatic model_clear();
    m_state  = M_IDLE;
    m_good   = 0;
    m_period = 8'd0;
    m_miss   = 8'd0;
  endtask

  // One slow-clock period of p cycles starting with a rising edge.
  task automatic run_period(input int p);
    @(negedge clk);
    bus.tick_in = 1'b1;
    model_rise(cyc, p);
    repeat (p / 2) @(negedge clk);
    bus.tick_in = 1'b0;
    repeat (p - p / 2 - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.tick_in = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.tick_pulse, bus.locked, bus.period, bus.err_short, bus.err_long, bus.miss_count} !== 20'd0) begin
      bad++;
      $display("FAIL reset_initial got lk=%b per=%0d miss=%0d want all zero", bus.locked, bus.period, bus.miss_count);
    end
    rst_n = 1'b1;
    repeat (6) run_period(NOM);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_before_reset got %b want 1", bus.locked);
    end
    @(negedge clk);
    bus.tick_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.tick_pulse, bus.locked, bus.period, bus.err_short, bus.err_long, bus.miss_count} !== 20'd0) begin
      bad++;
      $display("FAIL reset_async got lk=%b per=%0d miss=%0d want all zero", bus.locked, bus.period, bus.miss_count);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tick_in = ~bus.tick_in;
    end
    bus.tick_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    run_period(NOM);
    total++;
    if (bus.period !== 8'd0) begin
      bad++;
      $display("FAIL first_edge_period got %0d want 0", bus.period);
    end
  endtask

  task automatic test_lock();
    repeat (3) run_period(NOM);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL lock_early got %b want 0", bus.locked);
    end
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b1 || bus.period !== 8'd100) begin
      bad++;
      $display("FAIL lock_fifth got lk=%b per=%0d want lk=1 per=100", bus.locked, bus.period);
    end
  endtask

  task automatic test_short();
    run_period(90);
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b0 || bus.period !== 8'd90) begin
      bad++;
      $display("FAIL short_drop got lk=%b per=%0d want lk=0 per=90", bus.locked, bus.period);
    end
    repeat (3) run_period(NOM);
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL short_relock got %b want 1", bus.locked);
    end
  endtask

  task automatic test_timeout();
    run_period(300);
    total++;
    if (bus.locked !== 1'b0 || bus.miss_count !== 8'd1) begin
      bad++;
      $display("FAIL timeout_state got lk=%b miss=%0d want lk=0 miss=1", bus.locked, bus.miss_count);
    end
    repeat (4) run_period(NOM);
    total++;
    if (bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL timeout_relock_early got %b want 0", bus.locked);
    end
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL timeout_relock got %b want 1", bus.locked);
    end
  endtask

  task automatic test_boundaries();
    run_period(98);
    run_period(102);
    total++;
    if (bus.locked !== 1'b1 || bus.period !== 8'd98) begin
      bad++;
      $display("FAIL bound_98 got lk=%b per=%0d want lk=1 per=98", bus.locked, bus.period);
    end
    run_period(97);
    total++;
    if (bus.locked !== 1'b1 || bus.period !== 8'd102) begin
      bad++;
      $display("FAIL bound_102 got lk=%b per=%0d want lk=1 per=102", bus.locked, bus.period);
    end
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b0 || bus.period !== 8'd97) begin
      bad++;
      $display("FAIL bound_97 got lk=%b per=%0d want lk=0 per=97", bus.locked, bus.period);
    end
    repeat (4) run_period(NOM);
    run_period(103);
    run_period(NOM);
    total++;
    if (bus.locked !== 1'b0 || bus.miss_count !== 8'd2 || bus.period !== 8'd100) begin
      bad++;
      $display("FAIL bound_103 got lk=%b miss=%0d per=%0d want lk=0 miss=2 per=100",
               bus.locked, bus.miss_count, bus.period);
    end
    repeat (4) run_period(NOM);
  endtask

  task automatic test_internal_reset();
    total++;
    if (bus.locked !== 1'b1) begin
      bad++;
      $display("FAIL srst_pre_lock got %b want 1", bus.locked);
    end
    @(negedge clk);
    internal_reset = 1'b1;
    @(negedge clk);
    internal_reset = 1'b0;
    total++;
    if (bus.locked !== 1'b0 || bus.miss_count !== 8'd0 || bus.period !== 8'd0) begin
      bad++;
      $display("FAIL srst_clear got lk=%b miss=%0d per=%0d want all zero", bus.locked, bus.miss_count, bus.period);
    end
    model_clear();
    repeat (2) run_period(NOM);
    total++;
    if (bus.period !== 8'd100 || bus.locked !== 1'b0) begin
      bad++;
      $display("FAIL srst_restart got lk=%b per=%0d want lk=0 per=100", bus.locked, bus.period);
    end
  endtask

  initial begin
    bus.tick_in = 1'b0;
    test_reset();
    test_lock();
    test_short();
    test_timeout();
    test_boundaries();
    test_internal_reset();
    repeat (5) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events got %0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
